kamacore_lsu: RTL and testbench

//  Load/store unit: initiator side of the core's word-addressed data RAM (write

---
 rtl/kamacore_pkg.sv | 34 +++
 rtl/kamacore_lsu_lane.sv | 39 +++
 rtl/kamacore_lsu.sv | 122 ++++++++++++
 tb/tb_kamacore_lsu.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/kamacore_pkg.sv
// Shared widths, LSU access-size encodings, FSM state constants and request legality check.
package kamacore_pkg;

  localparam int unsigned CPU_WIDTH  = 32;
  localparam int unsigned ADDR_WIDTH = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef logic [1:0] lsu_state_e;
  localparam lsu_state_e LSU_IDLE = 2'd0;
  localparam lsu_state_e LSU_RD   = 2'd1;
  localparam lsu_state_e LSU_WR   = 2'd2;
  localparam lsu_state_e LSU_RESP = 2'd3;

  // Unsupported size, unsigned store, or misaligned H/W access.
  function automatic logic lsu_illegal(input logic we, input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
    logic bad;
    case (funct3)
      F3_B:         bad = 1'b0;
      F3_H:         bad = addr_lo[0];
      F3_W:         bad = |addr_lo;
      F3_BU:        bad = we;
      F3_HU:        bad = we | addr_lo[0];
      default:      bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/kamacore_lsu_lane.sv
// Byte-lane logic: load extract/extend and sub-word store merge, purely combinational.
module kamacore_lsu_lane
  import kamacore_pkg::*;
(
  input  logic [2:0]           funct3,
  input  logic [1:0]           addr_lo,
  input  logic [CPU_WIDTH-1:0] word,
  input  logic [CPU_WIDTH-1:0] wdata,
  output logic [CPU_WIDTH-1:0] rdata,
  output logic [CPU_WIDTH-1:0] merged
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word[{addr_lo, 3'b000} +: 8];
    half_v = word[{addr_lo[1], 4'b0000} +: 16];

    rdata = '0;
    case (funct3)
      F3_B:    rdata = {{24{byte_v[7]}}, byte_v};
      F3_BU:   rdata = {24'd0, byte_v};
      F3_H:    rdata = {{16{half_v[15]}}, half_v};
      F3_HU:   rdata = {16'd0, half_v};
      F3_W:    rdata = word;
      default: rdata = '0;
    endcase

    merged = word;
    case (funct3)
      F3_B:    merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      F3_H:    merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      F3_W:    merged = wdata;
      default: merged = word;
    endcase
  end

endmodule

// File: rtl/kamacore_lsu.sv
// Load/store unit: one byte-addressed request at a time onto a word RAM, with RMW for SB/SH.
module kamacore_lsu
  import kamacore_pkg::*;
#(
  parameter int unsigned MEM_ADDR_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [2:0]                req_funct3,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [CPU_WIDTH-1:0]      req_wdata,
  output logic                      rsp_valid,
  output logic [CPU_WIDTH-1:0]      rsp_rdata,
  output logic                      rsp_err,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_a,
  output logic [CPU_WIDTH-1:0]      mem_di,
  input  logic [CPU_WIDTH-1:0]      mem_spo
);

  lsu_state_e                state_q, state_d;
  logic                      we_q;
  logic [2:0]                funct3_q;
  logic [MEM_ADDR_WIDTH+1:0] addr_q;
  logic [CPU_WIDTH-1:0]      wdata_q;
  logic [CPU_WIDTH-1:0]      rdword_q;
  logic [MEM_ADDR_WIDTH-1:0] mem_a_q;
  logic [CPU_WIDTH-1:0]      rsp_rdata_q;
  logic                      rsp_err_q;

  logic                      accept;
  logic                      req_bad;
  logic [MEM_ADDR_WIDTH-1:0] word_idx;
  logic [CPU_WIDTH-1:0]      lane_word, lane_rdata, lane_merged;

  // Upper address bits fall outside the RAM and simply wrap.
  logic unused_addr;
  assign unused_addr = ^req_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2];

  assign req_ready = (state_q == LSU_IDLE) && rst_n;
  assign accept    = req_valid && req_ready;
  assign req_bad   = lsu_illegal(req_we, req_funct3, req_addr[1:0]);
  assign word_idx  = addr_q[MEM_ADDR_WIDTH+1:2];

  // RD extracts from live RAM data; WR merges into the word captured during RD.
  assign lane_word = (state_q == LSU_RD) ? mem_spo : rdword_q;

  kamacore_lsu_lane u_lane (
    .funct3  (funct3_q),
    .addr_lo (addr_q[1:0]),
    .word    (lane_word),
    .wdata   (wdata_q),
    .rdata   (lane_rdata),
    .merged  (lane_merged)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE: begin
        if (accept) begin
          if (req_bad)                             state_d = LSU_RESP;
          else if (req_we && req_funct3 == F3_W)   state_d = LSU_WR;
          else                                     state_d = LSU_RD;
        end
      end
      LSU_RD:   state_d = we_q ? LSU_WR : LSU_RESP;
      LSU_WR:   state_d = LSU_RESP;
      default:  state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= LSU_IDLE;
      we_q        <= 1'b0;
      funct3_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdword_q    <= '0;
      mem_a_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        LSU_IDLE: begin
          if (accept) begin
            we_q        <= req_we;
            funct3_q    <= req_funct3;
            addr_q      <= req_addr[MEM_ADDR_WIDTH+1:0];
            wdata_q     <= req_wdata;
            rsp_err_q   <= req_bad;
            rsp_rdata_q <= '0;
          end
        end
        LSU_RD: begin
          mem_a_q  <= word_idx;
          rdword_q <= mem_spo;
          if (!we_q) rsp_rdata_q <= lane_rdata;
        end
        LSU_WR: mem_a_q <= word_idx;
        default: begin
          rsp_rdata_q <= '0;
          rsp_err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_valid = (state_q == LSU_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  assign mem_we = (state_q == LSU_WR) && rst_n;
  assign mem_a  = (state_q == LSU_RD || state_q == LSU_WR) ? word_idx : mem_a_q;
  assign mem_di = (state_q == LSU_WR) ? lane_merged : mem_spo;

endmodule

// File: tb/tb_kamacore_lsu.sv
// Directed bench for kamacore_lsu with a behavioural 1024-word RAM.
module tb_kamacore_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic [9:0]  mem_a;
  logic [31:0] mem_di;
  logic [31:0] mem_spo;

  logic [31:0] mem [0:1023];
  int          we_edges;
  int          checks;
  int          failures;

  kamacore_lsu #(.MEM_ADDR_WIDTH(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_we     (mem_we),
    .mem_a      (mem_a),
    .mem_di     (mem_di),
    .mem_spo    (mem_spo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_spo = mem[mem_a];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_a] <= mem_di;
      we_edges   <= we_edges + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one request; report response data/err, latency and mem_we activity seen.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic err, output int lat, output int we_cnt,
                        output int we_cyc);
    int n;
    rdata = 32'hx; err = 1'bx; lat = 99; we_cnt = 0; we_cyc = -1;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (mem_we) begin
        we_cnt++;
        we_cyc = k;
      end
      if (rsp_valid) begin
        rdata = rsp_rdata;
        err   = rsp_err;
        lat   = k;
        break;
      end
    end
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat, wc, wcyc, base, n_rsp, acc_n;
  int          acc_cyc [4];
  logic [31:0] exp_b2b [4];

  initial begin
    checks = 0; failures = 0; we_edges = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", {31'd0, rsp_err}, 32'd0);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_mem_a", {22'd0, mem_a}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);

    // Loads with sign/zero extension.
    mem[1] = 32'h8081_7F02;
    do_req(1'b0, 3'b000, 32'h7, '0, rd, er, lat, wc, wcyc);
    check("lb7", rd, 32'hFFFF_FF80);
    check("lb7_lat", lat, 2);
    check("lb7_err", {31'd0, er}, 32'd0);
    do_req(1'b0, 3'b100, 32'h7, '0, rd, er, lat, wc, wcyc);
    check("lbu7", rd, 32'h0000_0080);
    do_req(1'b0, 3'b001, 32'h6, '0, rd, er, lat, wc, wcyc);
    check("lh6", rd, 32'hFFFF_8081);
    do_req(1'b0, 3'b101, 32'h6, '0, rd, er, lat, wc, wcyc);
    check("lhu6", rd, 32'h0000_8081);
    do_req(1'b0, 3'b000, 32'h5, '0, rd, er, lat, wc, wcyc);
    check("lb5", rd, 32'h0000_007F);
    do_req(1'b0, 3'b010, 32'h4, '0, rd, er, lat, wc, wcyc);
    check("lw4", rd, 32'h8081_7F02);
    check("lw4_lat", lat, 2);
    check("lw4_err", {31'd0, er}, 32'd0);
    // Address wraps within the 1024-word RAM.
    do_req(1'b0, 3'b010, 32'h0000_1004, '0, rd, er, lat, wc, wcyc);
    check("lw_wrap", rd, 32'h8081_7F02);

    // SB read-modify-write.
    mem[1] = 32'h1122_3344;
    do_req(1'b1, 3'b000, 32'h5, 32'hFFFF_FFA5, rd, er, lat, wc, wcyc);
    check("sb5_mem", mem[1], 32'h1122_A544);
    check("sb5_we_cnt", wc, 1);
    check("sb5_we_cyc", wcyc, 2);
    check("sb5_lat", lat, 3);
    check("sb5_rdata", rd, 32'd0);

    // SW then SH merge.
    do_req(1'b1, 3'b010, 32'h8, 32'hDEAD_BEEF, rd, er, lat, wc, wcyc);
    check("sw8_mem", mem[2], 32'hDEAD_BEEF);
    check("sw8_we_cyc", wcyc, 1);
    check("sw8_lat", lat, 2);
    do_req(1'b1, 3'b001, 32'hA, 32'h0000_1234, rd, er, lat, wc, wcyc);
    check("sha_mem", mem[2], 32'h1234_BEEF);
    check("sha_lat", lat, 3);

    // Error cases.
    base = we_edges;
    do_req(1'b0, 3'b010, 32'h6, '0, rd, er, lat, wc, wcyc);
    check("lw6_err", {31'd0, er}, 32'd1);
    check("lw6_rdata", rd, 32'd0);
    check("lw6_lat", lat, 1);
    do_req(1'b0, 3'b011, 32'h4, '0, rd, er, lat, wc, wcyc);
    check("f3_011_err", {31'd0, er}, 32'd1);
    check("f3_011_lat", lat, 1);
    do_req(1'b1, 3'b100, 32'h4, 32'h55, rd, er, lat, wc, wcyc);
    check("sbu_err", {31'd0, er}, 32'd1);
    do_req(1'b1, 3'b001, 32'h9, 32'h55, rd, er, lat, wc, wcyc);
    check("sh9_err", {31'd0, er}, 32'd1);
    check("err_no_write", we_edges - base, 0);
    check("err_mem2", mem[2], 32'h1234_BEEF);

    // Reset landing in RD, then in WR: no write, no response.
    for (int phase = 1; phase <= 2; phase++) begin
      mem[3] = 32'hCAFE_F00D;
      base  = we_edges;
      n_rsp = 0;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
      req_addr = 32'hC; req_wdata = 32'h77;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (phase) @(negedge clk);
      rst_n = 1'b0;
      #1;
      if (phase == 2) check("rstwr_mem_we_gated", {31'd0, mem_we}, 32'd0);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        if (rsp_valid) n_rsp++;
      end
      rst_n = 1'b1;
      #1;
      check(phase == 1 ? "rstrd_ready" : "rstwr_ready", {31'd0, req_ready}, 32'd1);
      repeat (4) begin
        @(negedge clk);
        if (rsp_valid) n_rsp++;
      end
      check(phase == 1 ? "rstrd_mem" : "rstwr_mem", mem[3], 32'hCAFE_F00D);
      check(phase == 1 ? "rstrd_nowr" : "rstwr_nowr", we_edges - base, 0);
      check(phase == 1 ? "rstrd_norsp" : "rstwr_norsp", n_rsp, 0);
    end

    // Back-to-back LWs with req_valid held high.
    for (int i = 0; i < 4; i++) begin
      mem[16 + i] = 32'hA000_0000 + i * 32'h111;
      exp_b2b[i]  = 32'hA000_0000 + i * 32'h111;
    end
    acc_n = 0; n_rsp = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (rsp_valid) begin
        if (n_rsp < 4) check($sformatf("b2b_rdata%0d", n_rsp), rsp_rdata, exp_b2b[n_rsp]);
        n_rsp++;
      end
      if (acc_n < 4) begin
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h40 + acc_n * 4;
      end else begin
        req_valid = 1'b0;
      end
      #1;
      if (req_valid && req_ready) acc_cyc[acc_n++] = cyc;
    end
    check("b2b_accepts", acc_n, 4);
    check("b2b_rsps", n_rsp, 4);
    for (int i = 1; i < 4; i++)
      check($sformatf("b2b_gap%0d", i), acc_cyc[i] - acc_cyc[i-1], 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
